// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with registered Moore strobes.
// Optional macro CTRL_MEM_WAIT_EN: FETCH and MEM wait for mem_ready, with a timeout into HALT.
module multicycle_controller #(
  parameter int unsigned OP_W  = 5,
  parameter int unsigned TMO_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] opcode,
  input  logic            flag_c,
  input  logic            flag_z,
  input  logic            mem_ready,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            jal,
  output logic            rf_wr_en,
  output logic            rf_wr_from,
  output logic            alu_op,
  output logic            alu_psw,
  output logic            mem_rd_en,
  output logic            mem_wr_en,
  output logic            out_en,
  output logic            halted,
  output logic            bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef struct packed {
    logic ir_load;
    logic pc_inc;
    logic pc_load;
    logic jal;
    logic rf_wr_en;
    logic rf_wr_from;
    logic alu_op;
    logic alu_psw;
    logic mem_rd_en;
    logic mem_wr_en;
    logic out_en;
    logic halted;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_MOV  = OP_W'(0),  OP_ADDI = OP_W'(1),  OP_SUBI = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LHI  = OP_W'(3),  OP_LLI  = OP_W'(4),  OP_LDR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STR  = OP_W'(6),  OP_ADD  = OP_W'(7),  OP_ADC  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(9),  OP_SBB  = OP_W'(10), OP_CMP  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BCC  = OP_W'(12), OP_BCS  = OP_W'(13), OP_BNE  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(15), OP_BAL  = OP_W'(16), OP_JMP  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_JALL = OP_W'(18), OP_JALR = OP_W'(19), OP_JR   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_OUTR = OP_W'(21), OP_HLT  = OP_W'(22);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              bus_err_q, bus_err_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              wait_ok_c, wait_tmo_c;
  logic              is_alu_c, is_taken_c;

`ifdef CTRL_MEM_WAIT_EN
  // Value of the wait counter on the cycle whose miss makes it reach 2^TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);
  assign wait_ok_c  = mem_ready;
  assign wait_tmo_c = !mem_ready && (tmo_q == TMO_LAST);
`else
  logic unused_ok;
  assign unused_ok  = mem_ready;
  assign wait_ok_c  = 1'b1;
  assign wait_tmo_c = 1'b0;
`endif

  assign is_alu_c = opcode_q inside {OP_MOV, OP_ADDI, OP_SUBI, OP_LHI, OP_LLI,
                                     OP_ADD, OP_ADC, OP_SUB, OP_SBB};

  // Branch decision uses the opcode entering EXEC and the flags present at that edge.
  always_comb begin
    is_taken_c = 1'b0;
    case (opcode_d)
      OP_BCC:                                   is_taken_c = !flag_c;
      OP_BCS:                                   is_taken_c = flag_c;
      OP_BNE:                                   is_taken_c = !flag_z;
      OP_BEQ:                                   is_taken_c = flag_z;
      OP_BAL, OP_JMP, OP_JALL, OP_JALR, OP_JR:  is_taken_c = 1'b1;
      default:                                  is_taken_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
      ctrl_q    <= ctrl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    tmo_d     = tmo_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH, S_MEM: begin
        if (wait_ok_c) begin
          tmo_d = '0;
          if (state_q == S_FETCH)      state_d = S_DECODE;
          else if (opcode_q == OP_LDR) state_d = S_WB;
          else                         state_d = S_FETCH;
        end else if (wait_tmo_c) begin
          tmo_d     = '0;
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        opcode_d = opcode;
        state_d  = (opcode >= OP_HLT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_alu_c)                                    state_d = S_WB;
        else if (opcode_q == OP_LDR || opcode_q == OP_STR) state_d = S_MEM;
        else                                             state_d = S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the upcoming state so they line up with it.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_rd_en = 1'b1;
        ctrl_d.ir_load   = 1'b1;
        ctrl_d.pc_inc    = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.alu_op   = opcode_d inside {OP_SUBI, OP_SUB, OP_SBB, OP_CMP};
        ctrl_d.alu_psw  = opcode_d inside {OP_ADDI, OP_SUBI, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP};
        ctrl_d.pc_load  = is_taken_c;
        ctrl_d.jal      = opcode_d inside {OP_JALL, OP_JALR};
        ctrl_d.rf_wr_en = opcode_d inside {OP_JALL, OP_JALR};
        ctrl_d.out_en   = (opcode_d == OP_OUTR);
      end
      S_MEM: begin
        ctrl_d.mem_rd_en = (opcode_d == OP_LDR);
        ctrl_d.mem_wr_en = (opcode_d == OP_STR);
      end
      S_WB: begin
        ctrl_d.rf_wr_en   = 1'b1;
        ctrl_d.rf_wr_from = (opcode_d == OP_LDR);
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  assign ir_load    = ctrl_q.ir_load;
  assign pc_inc     = ctrl_q.pc_inc;
  assign pc_load    = ctrl_q.pc_load;
  assign jal        = ctrl_q.jal;
  assign rf_wr_en   = ctrl_q.rf_wr_en;
  assign rf_wr_from = ctrl_q.rf_wr_from;
  assign alu_op     = ctrl_q.alu_op;
  assign alu_psw    = ctrl_q.alu_psw;
  assign mem_rd_en  = ctrl_q.mem_rd_en;
  assign mem_wr_en  = ctrl_q.mem_wr_en;
  assign out_en     = ctrl_q.out_en;
  assign halted     = ctrl_q.halted;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, random instruction stream
// against a per-cycle schedule model, async reset mid-store, and the mem-wait build when enabled.
module tb_multicycle_controller;

  localparam logic [12:0] V_IR  = 13'h1000, V_PCI = 13'h0800, V_PCL = 13'h0400;
  localparam logic [12:0] V_JAL = 13'h0200, V_RFW = 13'h0100, V_RFF = 13'h0080;
  localparam logic [12:0] V_ALU = 13'h0040, V_PSW = 13'h0020, V_MRD = 13'h0010;
  localparam logic [12:0] V_MWR = 13'h0008, V_OUT = 13'h0004, V_HLT = 13'h0002;
  localparam logic [12:0] V_BER = 13'h0001;
  localparam logic [12:0] V_FETCH = V_IR | V_PCI | V_MRD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, start = 1'b0, flag_c = 1'b0, flag_z = 1'b0, mem_ready = 1'b1;
  logic [4:0] opcode = '0;
  logic ir_load, pc_inc, pc_load, jal, rf_wr_en, rf_wr_from, alu_op, alu_psw;
  logic mem_rd_en, mem_wr_en, out_en, halted, bus_err;
  logic [12:0] outs;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.OP_W(5), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .jal(jal),
    .rf_wr_en(rf_wr_en), .rf_wr_from(rf_wr_from), .alu_op(alu_op), .alu_psw(alu_psw),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .out_en(out_en),
    .halted(halted), .bus_err(bus_err)
  );

  assign outs = {ir_load, pc_inc, pc_load, jal, rf_wr_en, rf_wr_from, alu_op, alu_psw,
                 mem_rd_en, mem_wr_en, out_en, halted, bus_err};

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    bit          c;
    bit          z;
    int          len;   // cycles FETCH to next FETCH, 0 = never returns (halts)
    logic [12:0] v2;    // outputs in the third cycle of the instruction
    logic [12:0] v3;    // outputs in the fourth cycle
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_outputs", outs, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int instr_len(input int op);
    if (op inside {0, 1, 2, 3, 4, 7, 8, 9, 10}) return 4;
    if (op == 5) return 5;
    if (op == 6) return 4;
    return 3;
  endfunction

  // Expected outputs in cycle k of an instruction (k = 0 is its FETCH).
  function automatic logic [12:0] exp_vec(input int op, input bit c, input bit z, input int k);
    logic [12:0] v;
    bit taken;
    v = '0;
    if (k == 0) return V_FETCH;
    if (k == 1) return '0;
    if (op >= 22) return V_HLT;
    if (k == 2) begin
      if (op inside {2, 9, 10, 11}) v |= V_ALU;
      if (op inside {1, 2, 7, 8, 9, 10, 11}) v |= V_PSW;
      case (op)
        12:      taken = !c;
        13:      taken = c;
        14:      taken = !z;
        15:      taken = z;
        16, 17, 18, 19, 20: taken = 1'b1;
        default: taken = 1'b0;
      endcase
      if (taken) v |= V_PCL;
      if (op inside {18, 19}) v |= V_JAL | V_RFW;
      if (op == 21) v |= V_OUT;
    end else if (k == 3) begin
      if (op == 5)      v = V_MRD;
      else if (op == 6) v = V_MWR;
      else              v = V_RFW;
    end else begin
      v = V_RFW | V_RFF;
    end
    return v;
  endfunction

  initial begin
    int len_seen;
    int op;
    int len;
    bit c, z;

    tbl[0]  = '{7,  0, 0, 4, V_PSW,                 V_RFW};
    tbl[1]  = '{9,  0, 0, 4, V_ALU | V_PSW,         V_RFW};
    tbl[2]  = '{0,  0, 0, 4, 13'h0,                 V_RFW};
    tbl[3]  = '{11, 1, 1, 3, V_ALU | V_PSW,         V_FETCH};
    tbl[4]  = '{5,  0, 0, 5, 13'h0,                 V_MRD};
    tbl[5]  = '{6,  0, 0, 4, 13'h0,                 V_MWR};
    tbl[6]  = '{15, 0, 1, 3, V_PCL,                 V_FETCH};
    tbl[7]  = '{15, 0, 0, 3, 13'h0,                 V_FETCH};
    tbl[8]  = '{12, 0, 0, 3, V_PCL,                 V_FETCH};
    tbl[9]  = '{13, 0, 1, 3, 13'h0,                 V_FETCH};
    tbl[10] = '{14, 1, 0, 3, V_PCL,                 V_FETCH};
    tbl[11] = '{18, 0, 0, 3, V_PCL | V_JAL | V_RFW, V_FETCH};
    tbl[12] = '{20, 1, 1, 3, V_PCL,                 V_FETCH};
    tbl[13] = '{21, 0, 0, 3, V_OUT,                 V_FETCH};
    tbl[14] = '{22, 0, 0, 0, V_HLT,                 V_HLT};
    tbl[15] = '{25, 0, 0, 0, V_HLT,                 V_HLT};
    tbl[16] = '{23, 1, 1, 0, V_HLT,                 V_HLT};
    tbl[17] = '{8,  1, 0, 4, V_PSW,                 V_RFW};

    // Stay in IDLE while start is low after reset.
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_hold", outs, '0);
    end

    foreach (tbl[i]) begin
      apply_reset();
      opcode   = 5'(tbl[i].op);
      flag_c   = tbl[i].c;
      flag_z   = tbl[i].z;
      start    = 1'b1;
      len_seen = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        start = 1'b0;
        if (k == 0) check($sformatf("tbl%0d_fetch", i), outs, V_FETCH);
        if (k == 2) check($sformatf("tbl%0d_cyc3", i), outs, tbl[i].v2);
        if (k == 3) check($sformatf("tbl%0d_cyc4", i), outs, tbl[i].v3);
        if (k > 0 && ir_load && len_seen == 0) len_seen = k;
      end
      check($sformatf("tbl%0d_len", i), 13'(len_seen), 13'(tbl[i].len));
    end

    // Async reset in the MEM cycle of a store.
    apply_reset();
    opcode = 5'd6;
    start  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      start = 1'b0;
    end
    check("str_mem_cycle", outs, V_MWR);
    #2 rst_n = 1'b0;
    #1 check("rst_async_clear", outs, '0);
    step();
    check("rst_held", outs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("post_rst_idle", outs, '0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("post_rst_restart", outs, V_FETCH);

    // Random back-to-back stream; opcode is scrambled once it should have been latched.
    apply_reset();
    start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 15) == 0) ? int'($urandom_range(22, 31)) : int'($urandom_range(0, 21));
      c  = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      opcode = 5'(op);
      flag_c = c;
      flag_z = z;
      if (op >= 22) begin
        for (int k = 0; k < 2; k++) begin
          step();
          start = 1'b0;
          check($sformatf("rnd%0d_op%0d_k%0d", n, op, k), outs, exp_vec(op, c, z, k));
        end
        len = int'($urandom_range(1, 3));
        for (int h = 0; h < len; h++) begin
          step();
          check($sformatf("rnd%0d_op%0d_halt%0d", n, op, h), outs, exp_vec(op, c, z, 2));
        end
        start = 1'b1;
      end else begin
        len = instr_len(op);
        for (int k = 0; k < len; k++) begin
          step();
          start = 1'($urandom_range(0, 1));
          check($sformatf("rnd%0d_op%0d_k%0d", n, op, k), outs, exp_vec(op, c, z, k));
          if (k >= 2) opcode = 5'($urandom);
        end
      end
    end
    step();
    start = 1'b0;
    check("rnd_final_fetch", outs, V_FETCH);

`ifdef CTRL_MEM_WAIT_EN
    // Fetch that never completes times out into HALT with bus_err.
    apply_reset();
    mem_ready = 1'b0;
    opcode    = 5'd7;
    start     = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      start = 1'b0;
      check($sformatf("wait_fetch%0d", k), outs, V_FETCH);
    end
    step();
    check("wait_timeout", outs, V_HLT | V_BER);
    // Fetch completing after three wait cycles proceeds normally.
    apply_reset();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      start = 1'b0;
      check($sformatf("wait_short%0d", k), outs, V_FETCH);
    end
    mem_ready = 1'b1;
    step();
    check("wait_decode", outs, '0);
    step();
    check("wait_exec", outs, V_PSW);
    step();
    check("wait_wb", outs, V_RFW);
    step();
    check("wait_refetch", outs, V_FETCH);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
